// File: rtl/cp0_exc_ctrl_if.sv
// ---------------------------------------------------------------------------
// cp0_exc_ctrl_if
//   Pipeline <-> CP0 exception controller bus.
//   master : pipeline side (drives irq/requests/mtc0, receives acks/redirect)
//   slave  : cp0_exc_ctrl side
//   irq is sized for the maximum of 8 lines; the controller uses the low NIRQ.
// ---------------------------------------------------------------------------
interface cp0_exc_ctrl_if;
  logic [7:0]  irq;
  logic        stall;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] cur_pc;
  logic        cur_bd;
  logic        eret;
  logic        mtc0;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        exc_ack;
  logic        int_ack;
  logic        flush;
  logic [1:0]  npc_sel;
  logic [31:0] npc;
  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;

  modport master (
    output irq, stall, exc_req, exc_code, cur_pc, cur_bd, eret,
           mtc0, cp0_addr, cp0_wdata,
    input  cp0_rdata, exc_ack, int_ack, flush, npc_sel, npc,
           status, cause, epc
  );

  modport slave (
    input  irq, stall, exc_req, exc_code, cur_pc, cur_bd, eret,
           mtc0, cp0_addr, cp0_wdata,
    output cp0_rdata, exc_ack, int_ack, flush, npc_sel, npc,
           status, cause, epc
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// ---------------------------------------------------------------------------
// cp0_exc_ctrl
//   Sequential CP0 exception/interrupt controller for the 5-stage MIPS
//   pipeline. Holds Status/Cause/EPC, synchronises the interrupt lines
//   (per-line level or rising-edge latched), arbitrates a pipeline exception
//   against pending interrupts and sequences the one-cycle flush/redirect
//   for exception entry and ERET.
// Ports
//   clk    : clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : cp0_exc_ctrl_if.slave -- irq/stall/exc_req/exc_code/cur_pc/
//            cur_bd/eret/mtc0/cp0_addr/cp0_wdata in; cp0_rdata/exc_ack/
//            int_ack/flush/npc_sel/npc/status/cause/epc out
// ---------------------------------------------------------------------------
module cp0_exc_ctrl #(
  parameter int          NIRQ      = 8,
  parameter logic [7:0]  EDGE_MASK = 8'h00,
  parameter logic [31:0] VEC_ADDR  = 32'h4
) (
  input logic           clk,
  input logic           rst_n,
  cp0_exc_ctrl_if.slave bus
);

  localparam logic [1:0] S_RUN    = 2'b00;
  localparam logic [1:0] S_ENTER  = 2'b01;
  localparam logic [1:0] S_RETURN = 2'b10;

  localparam logic [NIRQ-1:0] EMASK = EDGE_MASK[NIRQ-1:0];

  logic [1:0]      state_q, state_d;
  logic            ie_q, ie_d;
  logic            exl_q, exl_d;
  logic            bd_q, bd_d;
  logic [NIRQ-1:0] im_q, im_d;
  logic [NIRQ-1:0] ip_q, ip_d;
  logic [4:0]      code_q, code_d;
  logic [31:0]     epc_q, epc_d;
  logic [NIRQ-1:0] sync1_q, sync2_q, sync3_q;

  logic            in_run, int_cond;
  logic            take_exc, take_int, take_eret, take_any, wr_en;
  logic [NIRQ-1:0] rise, w1c;
  logic [31:0]     epc_entry;
  logic [31:0]     status_w, cause_w;
  logic            unused_w;

  assign in_run   = (state_q == S_RUN);
  assign int_cond = ie_q & ~exl_q & |(ip_q & im_q);

  // Exception beats interrupt beats ERET; nothing is taken while stalled
  // or while a redirect is in flight.
  assign take_exc  = in_run & ~bus.stall & bus.exc_req;
  assign take_int  = in_run & ~bus.stall & ~bus.exc_req & int_cond;
  assign take_eret = in_run & ~bus.stall & ~bus.exc_req & ~int_cond & bus.eret;
  assign take_any  = take_exc | take_int | take_eret;

  // An mtc0 that coincides with an accepted event belongs to a cancelled
  // instruction, so it is dropped.
  assign wr_en = in_run & bus.mtc0 & ~take_any;

  // sync3 is the previous synchronised value; rise is valid one cycle.
  assign rise = sync2_q & ~sync3_q;
  assign w1c  = (wr_en && bus.cp0_addr == 5'd13) ? (bus.cp0_wdata[8 +: NIRQ] & EMASK) : '0;

  // A delay-slot instruction restarts at its branch (wraps mod 2^32).
  assign epc_entry = bus.cur_bd ? (bus.cur_pc - 32'd4) : bus.cur_pc;

  always_comb begin
    state_d = state_q;
    ie_d    = ie_q;
    exl_d   = exl_q;
    bd_d    = bd_q;
    im_d    = im_q;
    code_d  = code_q;
    epc_d   = epc_q;
    // Edge lines: sticky, cleared by W1C, a same-cycle edge wins.
    // Level lines: follow the synchronised input.
    ip_d    = (EMASK & ((ip_q & ~w1c) | rise)) | (~EMASK & sync2_q);

    if (wr_en) begin
      case (bus.cp0_addr)
        5'd12: begin
          ie_d  = bus.cp0_wdata[0];
          exl_d = bus.cp0_wdata[1];
          im_d  = bus.cp0_wdata[8 +: NIRQ];
        end
        5'd14:   epc_d = bus.cp0_wdata;
        default: ;
      endcase
    end

    if (take_exc || take_int) begin
      exl_d   = 1'b1;
      code_d  = take_exc ? bus.exc_code : 5'd0;
      // Nested entry keeps the original return point.
      if (!exl_q) begin
        epc_d = epc_entry;
        bd_d  = bus.cur_bd;
      end
      state_d = S_ENTER;
    end else if (take_eret) begin
      exl_d   = 1'b0;
      state_d = S_RETURN;
    end else if (!in_run) begin
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      ie_q    <= 1'b0;
      exl_q   <= 1'b0;
      bd_q    <= 1'b0;
      im_q    <= '0;
      ip_q    <= '0;
      code_q  <= 5'd0;
      epc_q   <= 32'd0;
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      state_q <= state_d;
      ie_q    <= ie_d;
      exl_q   <= exl_d;
      bd_q    <= bd_d;
      im_q    <= im_d;
      ip_q    <= ip_d;
      code_q  <= code_d;
      epc_q   <= epc_d;
      sync1_q <= bus.irq[NIRQ-1:0];
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  always_comb begin
    status_w              = '0;
    status_w[0]           = ie_q;
    status_w[1]           = exl_q;
    status_w[8 +: NIRQ]   = im_q;
    cause_w               = '0;
    cause_w[31]           = bd_q;
    cause_w[8 +: NIRQ]    = ip_q;
    cause_w[6:2]          = code_q;
  end

  always_comb begin
    case (bus.cp0_addr)
      5'd12:   bus.cp0_rdata = status_w;
      5'd13:   bus.cp0_rdata = cause_w;
      5'd14:   bus.cp0_rdata = epc_q;
      default: bus.cp0_rdata = 32'd0;
    endcase
  end

  assign bus.exc_ack = take_exc;
  assign bus.int_ack = take_int;
  assign bus.flush   = (state_q == S_ENTER) || (state_q == S_RETURN);
  assign bus.npc_sel = (state_q == S_ENTER)  ? 2'b01 :
                       (state_q == S_RETURN) ? 2'b10 : 2'b00;
  assign bus.npc     = (state_q == S_ENTER)  ? VEC_ADDR :
                       (state_q == S_RETURN) ? epc_q : 32'd0;
  assign bus.status  = status_w;
  assign bus.cause   = cause_w;
  assign bus.epc     = epc_q;

  // Bits of the shared bus that this configuration does not decode.
  assign unused_w = ^{bus.cp0_wdata, bus.irq};

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cp0_exc_ctrl
//   Scoreboard bench for cp0_exc_ctrl (NIRQ=8, irq[0] edge mode, others
//   level). Stimulus pushes expected ack/redirect cycles into a queue; a
//   negedge monitor pops one entry for every cycle with exc_ack, int_ack or
//   flush and compares cycle number and outputs.
// ---------------------------------------------------------------------------
module tb_cp0_exc_ctrl;

  typedef struct {
    string       name;
    int          cyc;
    logic        ea;
    logic        ia;
    logic        fl;
    logic [1:0]  sel;
    logic [31:0] npc;
    logic [31:0] st;
    logic [31:0] ca;
    logic [31:0] ep;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_run;
  int   n_fail;
  int   t;
  exp_t exp_q[$];

  cp0_exc_ctrl_if bus ();

  cp0_exc_ctrl #(
    .NIRQ      (8),
    .EDGE_MASK (8'h01),
    .VEC_ADDR  (32'h4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  task automatic expect_ev(input string n, input int c, input logic ea, input logic ia,
                           input logic fl, input logic [1:0] sel, input logic [31:0] npc,
                           input logic [31:0] st, input logic [31:0] ca, input logic [31:0] ep);
    exp_t e;
    e.name = n; e.cyc = c; e.ea = ea; e.ia = ia; e.fl = fl; e.sel = sel;
    e.npc = npc; e.st = st; e.ca = ca; e.ep = ep;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    bus.mtc0      = 1'b1;
    bus.cp0_addr  = addr;
    bus.cp0_wdata = data;
    step();
    bus.mtc0      = 1'b0;
  endtask

  // Monitor: one scoreboard entry per event cycle.
  always @(negedge clk) begin
    if (rst_n && (bus.exc_ack || bus.int_ack || bus.flush)) begin
      n_run++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got cyc=%0d exc_ack=%b int_ack=%b flush=%b, required no event",
                 cyc, bus.exc_ack, bus.int_ack, bus.flush);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (cyc != e.cyc || bus.exc_ack !== e.ea || bus.int_ack !== e.ia ||
            bus.flush !== e.fl || bus.npc_sel !== e.sel ||
            (e.sel != 2'b00 && bus.npc !== e.npc) ||
            bus.status !== e.st || bus.cause !== e.ca || bus.epc !== e.ep) begin
          n_fail++;
          $display("FAIL %s: got cyc=%0d ea=%b ia=%b fl=%b sel=%b npc=%h st=%h ca=%h epc=%h; expected cyc=%0d ea=%b ia=%b fl=%b sel=%b npc=%h st=%h ca=%h epc=%h",
                   e.name, cyc, bus.exc_ack, bus.int_ack, bus.flush, bus.npc_sel, bus.npc,
                   bus.status, bus.cause, bus.epc,
                   e.cyc, e.ea, e.ia, e.fl, e.sel, e.npc, e.st, e.ca, e.ep);
        end
      end
    end
  end

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.irq = 8'h00; bus.stall = 1'b0; bus.exc_req = 1'b0; bus.exc_code = 5'd0;
    bus.cur_pc = 32'd0; bus.cur_bd = 1'b0; bus.eret = 1'b0; bus.mtc0 = 1'b0;
    bus.cp0_addr = 5'd0; bus.cp0_wdata = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_status", bus.status, 32'h0);
    chk("rst_cause", bus.cause, 32'h0);
    chk("rst_epc", bus.epc, 32'h0);
    chk("rst_flush", {31'd0, bus.flush}, 32'h0);
    chk("rst_npc_sel", {30'd0, bus.npc_sel}, 32'h0);

    // Level irq[2] with IE=1, IM[10]=1: int_ack three cycles after the line rises
    wr(5'd12, 32'h0000_0401);
    bus.cur_pc = 32'h100;
    bus.irq    = 8'h04;
    t = cyc;
    expect_ev("t2_int_ack", t + 3, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h401, 32'h400, 32'h0);
    expect_ev("t2_enter",   t + 4, 1'b0, 1'b0, 1'b1, 2'b01, 32'h4, 32'h403, 32'h400, 32'h100);
    repeat (5) step();

    // Exception beats a pending interrupt; delay-slot EPC = pc-4, BD=1
    wr(5'd12, 32'h0000_0401);
    bus.exc_req = 1'b1; bus.exc_code = 5'd12; bus.cur_bd = 1'b1; bus.cur_pc = 32'h204;
    t = cyc;
    expect_ev("t3_exc_ack", t,     1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h401, 32'h0000_0400, 32'h100);
    expect_ev("t3_enter",   t + 1, 1'b0, 1'b0, 1'b1, 2'b01, 32'h4, 32'h403, 32'h8000_0430, 32'h200);
    step();
    bus.exc_req = 1'b0; bus.cur_bd = 1'b0; bus.irq = 8'h00;
    repeat (4) step();

    // Nested exception keeps EPC/BD; ERET returns to the original EPC
    bus.exc_req = 1'b1; bus.exc_code = 5'd9; bus.cur_pc = 32'h300; bus.cur_bd = 1'b0;
    t = cyc;
    expect_ev("t4_exc_ack", t,     1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h403, 32'h8000_0030, 32'h200);
    expect_ev("t4_enter",   t + 1, 1'b0, 1'b0, 1'b1, 2'b01, 32'h4, 32'h403, 32'h8000_0024, 32'h200);
    step();
    bus.exc_req = 1'b0;
    step();
    bus.eret = 1'b1;
    t = cyc;
    expect_ev("t4_return", t + 1, 1'b0, 1'b0, 1'b1, 2'b10, 32'h200, 32'h401, 32'h8000_0024, 32'h200);
    step();
    bus.eret = 1'b0;
    step();
    // ERET with EXL already 0 still redirects to EPC
    bus.eret = 1'b1;
    t = cyc;
    expect_ev("t4_return_exl0", t + 1, 1'b0, 1'b0, 1'b1, 2'b10, 32'h200, 32'h401, 32'h8000_0024, 32'h200);
    step();
    bus.eret = 1'b0;
    step();

    // Edge irq[0]: one-cycle pulse latches IP[8]; W1C clears; edge+W1C keeps it
    wr(5'd12, 32'h0000_0100);
    bus.irq = 8'h01;
    step();
    bus.irq = 8'h00;
    repeat (3) step();
    chk("t5_ip_latched", {24'd0, bus.cause[15:8]}, 32'h01);
    wr(5'd13, 32'h0000_0100);
    chk("t5_ip_w1c", {24'd0, bus.cause[15:8]}, 32'h00);
    bus.irq = 8'h01;
    step();
    bus.irq = 8'h00;
    step();
    wr(5'd13, 32'h0000_0100);
    chk("t5_edge_wins_w1c", {24'd0, bus.cause[15:8]}, 32'h01);
    wr(5'd13, 32'h0000_0100);
    chk("t5_ip_cleared", {24'd0, bus.cause[15:8]}, 32'h00);

    // Stall holds off exc_req; mtc0 in the acceptance cycle is dropped
    bus.stall = 1'b1; bus.exc_req = 1'b1; bus.exc_code = 5'd13;
    bus.cur_pc = 32'h400; bus.cur_bd = 1'b0;
    repeat (5) step();
    bus.stall = 1'b0;
    bus.mtc0 = 1'b1; bus.cp0_addr = 5'd14; bus.cp0_wdata = 32'hDEAD_0000;
    t = cyc;
    expect_ev("t6_exc_ack", t,     1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h100, 32'h8000_0024, 32'h200);
    expect_ev("t6_enter",   t + 1, 1'b0, 1'b0, 1'b1, 2'b01, 32'h4, 32'h102, 32'h0000_0034, 32'h400);
    step();
    bus.mtc0 = 1'b0; bus.exc_req = 1'b0;

    // Asynchronous reset in the middle of ENTER
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t1_rst_flush", {31'd0, bus.flush}, 32'h0);
    chk("t1_rst_npc_sel", {30'd0, bus.npc_sel}, 32'h0);
    chk("t1_rst_status", bus.status, 32'h0);
    chk("t1_rst_cause", bus.cause, 32'h0);
    chk("t1_rst_epc", bus.epc, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    // Back in RUN: an exception is accepted immediately
    bus.exc_req = 1'b1; bus.exc_code = 5'd8; bus.cur_pc = 32'h500; bus.cur_bd = 1'b0;
    t = cyc;
    expect_ev("t1_post_rst_ack",   t,     1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0,  32'h0);
    expect_ev("t1_post_rst_enter", t + 1, 1'b0, 1'b0, 1'b1, 2'b01, 32'h4, 32'h2, 32'h20, 32'h500);
    step();
    bus.exc_req = 1'b0;
    repeat (2) step();

    // mfc0 read port
    bus.cp0_addr = 5'd14;
    #1 chk("rd_epc", bus.cp0_rdata, 32'h500);
    bus.cp0_addr = 5'd12;
    #1 chk("rd_status", bus.cp0_rdata, 32'h2);
    bus.cp0_addr = 5'd5;
    #1 chk("rd_other", bus.cp0_rdata, 32'h0);

    repeat (2) step();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
